// File: rtl/flit_injector.sv
// Transmit-side flit serialiser: turns packet descriptors plus payload words into
// HEAD/BODY/TAIL (or HEADTAIL) flits on one router input link, with per-VC flow control.

package noc_params;
    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X  = 4;
    localparam int DEST_ADDR_SIZE_Y  = 4;
    localparam int HEAD_PAYLOAD_SIZE = 16;
    localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;
endpackage

module flit_injector
    import noc_params::*;
#(
    parameter int MAX_PKT_LEN = 16,
    parameter int HOLDOFF     = 2,
    parameter int LEN_W       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid_i,
    output logic                         pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]  x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]  y_dest_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0] head_pl_i,
    input  logic [LEN_W-1:0]             pkt_len_i,
    input  logic                         pl_valid_i,
    input  logic [FLIT_DATA_SIZE-1:0]    pl_data_i,
    output logic                         pl_ready_o,
    input  logic [VC_NUM-1:0]            on_off_i,
    input  logic [VC_NUM-1:0]            is_empty_i,
    output flit_t                        data_o,
    output logic                         valid_flit_o,
    output logic                         busy_o
);

    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BT} state_t;

    state_t                       r_state, w_state_nxt;
    logic [VC_SIZE-1:0]           r_rr, r_vc, w_pick;
    logic [HO_W-1:0]              r_holdoff [VC_NUM];
    logic [VC_NUM-1:0]            w_elig;
    logic                         w_any_elig, w_accept, w_send, w_last;
    logic [LEN_W-1:0]             r_len, r_remaining, w_remaining_nxt;
    logic [DEST_ADDR_SIZE_X-1:0]  r_x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  r_y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] r_head_pl;
    flit_t                        r_data, w_flit;
    logic                         r_valid;

    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            w_elig[v] = on_off_i[v] & is_empty_i[v] & (r_holdoff[v] == '0);
        end
    end

    // Round-robin search: first eligible VC at or after the pointer, wrapping.
    always_comb begin
        int idx;
        w_pick     = '0;
        w_any_elig = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = (int'(r_rr) + i) % VC_NUM;
            if (!w_any_elig && w_elig[idx]) begin
                w_pick     = VC_SIZE'(idx);
                w_any_elig = 1'b1;
            end
        end
    end

    assign pkt_ready_o = (r_state == S_IDLE) & w_any_elig;
    assign w_accept    = pkt_valid_i & pkt_ready_o;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt     = r_state;
        w_send          = 1'b0;
        w_last          = 1'b0;
        w_remaining_nxt = r_remaining;
        pl_ready_o      = 1'b0;
        w_flit          = r_data;
        w_flit.vc_id    = r_vc;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_HEAD;
            end
            S_HEAD: begin
                w_flit.data.head_data.x_dest  = r_x_dest;
                w_flit.data.head_data.y_dest  = r_y_dest;
                w_flit.data.head_data.head_pl = r_head_pl;
                if (on_off_i[r_vc]) begin
                    w_send = 1'b1;
                    if (r_len == LEN_W'(1)) begin
                        w_flit.flit_label = HEADTAIL;
                        w_last            = 1'b1;
                        w_state_nxt       = S_IDLE;
                    end else begin
                        w_flit.flit_label = HEAD;
                        w_remaining_nxt   = r_len - LEN_W'(1);
                        w_state_nxt       = S_BT;
                    end
                end
            end
            S_BT: begin
                pl_ready_o        = on_off_i[r_vc];
                w_flit.data.bt_pl = pl_data_i;
                if (pl_valid_i && on_off_i[r_vc]) begin
                    w_send          = 1'b1;
                    w_remaining_nxt = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_flit.flit_label = TAIL;
                        w_last            = 1'b1;
                        w_state_nxt       = S_IDLE;
                    end else begin
                        w_flit.flit_label = BODY;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_valid     <= w_send;
            if (w_send) r_data <= w_flit;
            if (w_accept) r_rr <= (w_pick == VC_SIZE'(VC_NUM - 1)) ? '0 : w_pick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int v = 0; v < VC_NUM; v++) begin
            if (!rst) begin
                r_holdoff[v] <= '0;
            end else if (w_last && (r_vc == VC_SIZE'(v))) begin
                r_holdoff[v] <= HO_W'(HOLDOFF);
            end else if (r_holdoff[v] != '0) begin
                r_holdoff[v] <= r_holdoff[v] - 1'b1;
            end
        end
    end

    // NOTE: descriptor capture registers carry no reset; they are always written on accept before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_vc      <= w_pick;
            r_x_dest  <= x_dest_i;
            r_y_dest  <= y_dest_i;
            r_head_pl <= head_pl_i;
            r_len     <= (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;
        end
    end

    assign data_o       = r_data;
    assign valid_flit_o = r_valid;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: basic, single-flit, stall, VC rotation/holdoff,
// payload starvation, reset mid-packet and zero-length descriptor.

module tb_flit_injector;
    import noc_params::*;

    localparam int LEN_W = 5;

    logic                         clk;
    logic                         rst;
    logic                         pkt_valid_i;
    logic                         pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest_i;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest_i;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl_i;
    logic [LEN_W-1:0]             pkt_len_i;
    logic                         pl_valid_i;
    logic [FLIT_DATA_SIZE-1:0]    pl_data_i;
    logic                         pl_ready_o;
    logic [VC_NUM-1:0]            on_off_i;
    logic [VC_NUM-1:0]            is_empty_i;
    flit_t                        data_o;
    logic                         valid_flit_o;
    logic                         busy_o;

    int n_vec = 0;
    int n_err = 0;

    flit_injector #(.MAX_PKT_LEN(16), .HOLDOFF(2), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .pkt_valid_i (pkt_valid_i),
        .pkt_ready_o (pkt_ready_o),
        .x_dest_i    (x_dest_i),
        .y_dest_i    (y_dest_i),
        .head_pl_i   (head_pl_i),
        .pkt_len_i   (pkt_len_i),
        .pl_valid_i  (pl_valid_i),
        .pl_data_i   (pl_data_i),
        .pl_ready_o  (pl_ready_o),
        .on_off_i    (on_off_i),
        .is_empty_i  (is_empty_i),
        .data_o      (data_o),
        .valid_flit_o(valid_flit_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flit(input string tag, input flit_label_t lbl, input int vc,
                            input logic [FLIT_DATA_SIZE-1:0] pl);
        chk({tag, "_valid"}, 64'(valid_flit_o), 64'd1);
        chk({tag, "_label"}, 64'(data_o.flit_label), 64'(lbl));
        chk({tag, "_vc"}, 64'(data_o.vc_id), 64'(vc));
        chk({tag, "_data"}, 64'(data_o.data.bt_pl), 64'(pl));
    endtask

    initial begin
        rst = 1'b0; pkt_valid_i = 1'b0; x_dest_i = '0; y_dest_i = '0; head_pl_i = '0;
        pkt_len_i = '0; pl_valid_i = 1'b0; pl_data_i = '0; on_off_i = '1; is_empty_i = '1;

        // Reset state
        tick(); tick();
        chk("rst_valid", 64'(valid_flit_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        rst = 1'b1; #1;
        chk("rst_pkt_ready", 64'(pkt_ready_o), 64'd1);
        chk("rst_pl_ready", 64'(pl_ready_o), 64'd0);

        // Basic 4-flit packet on VC0
        pkt_valid_i = 1'b1; x_dest_i = 4'd3; y_dest_i = 4'd5; head_pl_i = 16'hA001;
        pkt_len_i = 5'd4; pl_valid_i = 1'b1; pl_data_i = 24'h0B0001;
        tick();
        pkt_valid_i = 1'b0; #1;
        chk("b_busy", 64'(busy_o), 64'd1);
        chk("b_nohead_yet", 64'(valid_flit_o), 64'd0);
        chk("b_plr_head", 64'(pl_ready_o), 64'd0);
        chk("b_pktr_busy", 64'(pkt_ready_o), 64'd0);
        tick();
        chk_flit("b_head", HEAD, 0, {4'd3, 4'd5, 16'hA001});
        chk("b_plr_bt", 64'(pl_ready_o), 64'd1);
        tick();
        chk_flit("b_body1", BODY, 0, 24'h0B0001);
        pl_data_i = 24'h0B0002;
        tick();
        chk_flit("b_body2", BODY, 0, 24'h0B0002);
        pl_data_i = 24'h0B0003;
        tick();
        chk_flit("b_tail", TAIL, 0, 24'h0B0003);
        chk("b_idle", 64'(busy_o), 64'd0);
        pl_valid_i = 1'b0; #1;
        chk("b_pktr_after", 64'(pkt_ready_o), 64'd1);
        tick();
        chk("b_bubble", 64'(valid_flit_o), 64'd0);

        // Single-flit packet -> HEADTAIL on VC1
        pkt_valid_i = 1'b1; x_dest_i = 4'd7; y_dest_i = 4'd2; head_pl_i = 16'hBEEF; pkt_len_i = 5'd1;
        tick();
        pkt_valid_i = 1'b0; #1;
        chk("s_plr_head", 64'(pl_ready_o), 64'd0);
        tick();
        chk_flit("s_ht", HEADTAIL, 1, {4'd7, 4'd2, 16'hBEEF});
        chk("s_idle", 64'(busy_o), 64'd0);
        chk("s_plr_idle", 64'(pl_ready_o), 64'd0);
        tick();
        chk("s_valid_clr", 64'(valid_flit_o), 64'd0);
        chk("s_data_hold", 64'(data_o.flit_label), 64'(HEADTAIL));

        // Flow-control stall, 6 flits on VC2
        pkt_valid_i = 1'b1; x_dest_i = 4'd1; y_dest_i = 4'd1; head_pl_i = 16'h0001; pkt_len_i = 5'd6;
        pl_valid_i = 1'b1; pl_data_i = 24'h0C0001;
        tick();
        pkt_valid_i = 1'b0;
        tick();
        chk_flit("f_head", HEAD, 2, {4'd1, 4'd1, 16'h0001});
        tick();
        chk_flit("f_body1", BODY, 2, 24'h0C0001);
        pl_data_i = 24'h0C0002;
        tick();
        chk_flit("f_body2", BODY, 2, 24'h0C0002);
        on_off_i = 4'b1011; pl_data_i = 24'h0C0003; #1;
        chk("f_plr_off", 64'(pl_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("f_stall%0d_valid", i), 64'(valid_flit_o), 64'd0);
            chk($sformatf("f_stall%0d_plr", i), 64'(pl_ready_o), 64'd0);
            chk($sformatf("f_stall%0d_hold", i), 64'(data_o.data.bt_pl), 64'h0C0002);
        end
        on_off_i = '1;
        tick();
        chk_flit("f_body3", BODY, 2, 24'h0C0003);
        pl_data_i = 24'h0C0004;
        tick();
        chk_flit("f_body4", BODY, 2, 24'h0C0004);
        pl_data_i = 24'h0C0005;
        tick();
        chk_flit("f_tail", TAIL, 2, 24'h0C0005);
        chk("f_idle", 64'(busy_o), 64'd0);
        pl_valid_i = 1'b0;

        // Single flit on VC3 brings the pointer back to VC0
        pkt_valid_i = 1'b1; x_dest_i = 4'd0; y_dest_i = 4'd0; head_pl_i = 16'h3333; pkt_len_i = 5'd1;
        tick();
        pkt_valid_i = 1'b0;
        tick();
        chk_flit("r_vc3", HEADTAIL, 3, {4'd0, 4'd0, 16'h3333});

        // Three back-to-back 2-flit packets rotate VC0, VC1, VC2
        pl_valid_i = 1'b1; pkt_len_i = 5'd2;
        for (int k = 0; k < 3; k++) begin
            pkt_valid_i = 1'b1; head_pl_i = 16'h0A00 + 16'(k); pl_data_i = 24'h0A0000 + 24'(k);
            #1;
            chk($sformatf("rot%0d_pktr", k), 64'(pkt_ready_o), 64'd1);
            tick();
            pkt_valid_i = 1'b0;
            tick();
            chk_flit($sformatf("rot%0d_head", k), HEAD, k, {4'd0, 4'd0, 16'h0A00 + 16'(k)});
            tick();
            chk_flit($sformatf("rot%0d_tail", k), TAIL, k, 24'h0A0000 + 24'(k));
        end

        // Holdoff: only VC0 empty, blocked for two cycles after its HEADTAIL
        pl_valid_i = 1'b0; is_empty_i = 4'b0001;
        pkt_valid_i = 1'b1; head_pl_i = 16'h0000; pkt_len_i = 5'd1; #1;
        chk("h_pktr0", 64'(pkt_ready_o), 64'd1);
        tick();
        pkt_valid_i = 1'b0;
        tick();
        chk_flit("h_ht0", HEADTAIL, 0, {4'd0, 4'd0, 16'h0000});
        pkt_valid_i = 1'b1; head_pl_i = 16'h1111; #1;
        chk("h_blocked1", 64'(pkt_ready_o), 64'd0);
        tick();
        chk("h_blocked2", 64'(pkt_ready_o), 64'd0);
        chk("h_no_flit", 64'(valid_flit_o), 64'd0);
        tick();
        chk("h_released", 64'(pkt_ready_o), 64'd1);
        tick();
        pkt_valid_i = 1'b0;
        tick();
        chk_flit("h_ht1", HEADTAIL, 0, {4'd0, 4'd0, 16'h1111});
        is_empty_i = '1;

        // Payload starvation, 3 flits on VC1
        pkt_valid_i = 1'b1; head_pl_i = 16'h5555; pkt_len_i = 5'd3; pl_valid_i = 1'b0;
        tick();
        pkt_valid_i = 1'b0;
        tick();
        chk_flit("p_head", HEAD, 1, {4'd0, 4'd0, 16'h5555});
        chk("p_plr", 64'(pl_ready_o), 64'd1);
        tick();
        chk("p_bubble1", 64'(valid_flit_o), 64'd0);
        tick();
        chk("p_bubble2", 64'(valid_flit_o), 64'd0);
        chk("p_still_busy", 64'(busy_o), 64'd1);
        pl_valid_i = 1'b1; pl_data_i = 24'h0D0001;
        tick();
        chk_flit("p_body", BODY, 1, 24'h0D0001);
        pl_data_i = 24'h0D0002;
        tick();
        chk_flit("p_tail", TAIL, 1, 24'h0D0002);

        // Reset during a 16-flit packet on VC2
        pkt_valid_i = 1'b1; head_pl_i = 16'h6666; pkt_len_i = 5'd16; pl_data_i = 24'h0E0001;
        tick();
        pkt_valid_i = 1'b0;
        tick();
        chk_flit("x_head", HEAD, 2, {4'd0, 4'd0, 16'h6666});
        tick();
        chk_flit("x_body1", BODY, 2, 24'h0E0001);
        tick();
        chk("x_busy", 64'(busy_o), 64'd1);
        rst = 1'b0;
        tick();
        chk("x_valid", 64'(valid_flit_o), 64'd0);
        chk("x_busy_clr", 64'(busy_o), 64'd0);
        chk("x_data_clr", 64'(data_o), 64'd0);
        rst = 1'b1; #1;
        chk("x_pktr", 64'(pkt_ready_o), 64'd1);
        pkt_valid_i = 1'b1; head_pl_i = 16'h7777; pkt_len_i = 5'd2; pl_data_i = 24'h0F0001;
        tick();
        pkt_valid_i = 1'b0;
        tick();
        chk_flit("x_new_head", HEAD, 0, {4'd0, 4'd0, 16'h7777});
        tick();
        chk_flit("x_new_tail", TAIL, 0, 24'h0F0001);

        // Zero length descriptor behaves as a single flit
        pkt_valid_i = 1'b1; head_pl_i = 16'h8888; pkt_len_i = 5'd0; pl_valid_i = 1'b0;
        tick();
        pkt_valid_i = 1'b0;
        tick();
        chk_flit("z_ht", HEADTAIL, 1, {4'd0, 4'd0, 16'h8888});
        chk("z_idle", 64'(busy_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flit_injector.md
Name: flit_injector

Overview:
- Transmit-side partner of input_port: sits in the network interface (or upstream link stage) and serialises packets into HEAD/BODY/TAIL (or HEADTAIL) flits on one router input link.
- Picks a downstream VC per packet, stamps it in vc_id, and obeys per-VC on/off flow control and buffer-empty status from input_port.
- Uses flit_t, flit_label_t, VC_NUM, VC_SIZE and the DEST_ADDR/payload widths from noc_params.

Parameters:
MAX_PKT_LEN, 16, maximum flits per packet including HEAD; LEN_W = $clog2(MAX_PKT_LEN+1)
HOLDOFF, 2, cycles a VC stays ineligible for a new packet after its TAIL/HEADTAIL is sent; covers link latency before is_empty_i is valid

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (rst==0 resets on rising clk)
pkt_valid_i  in  1  packet descriptor valid
pkt_ready_o  out  1  descriptor accepted this cycle when both valid and ready are high
x_dest_i  in  DEST_ADDR_SIZE_X  destination x
y_dest_i  in  DEST_ADDR_SIZE_Y  destination y
head_pl_i  in  HEAD_PAYLOAD_SIZE  HEAD payload
pkt_len_i  in  LEN_W  total flits in packet (1..MAX_PKT_LEN)
pl_valid_i  in  1  BODY/TAIL payload word valid
pl_data_i  in  FLIT_DATA_SIZE  BODY/TAIL payload
pl_ready_o  out  1  payload word consumed this cycle
on_off_i  in  VC_NUM  downstream per-VC on/off (1 = may send)
is_empty_i  in  VC_NUM  downstream per-VC buffer empty
data_o  out  flit_t  registered output flit
valid_flit_o  out  1  data_o valid this cycle
busy_o  out  1  packet in progress (state != IDLE)

Behaviour:
- Reset (rst==0 at rising edge): state IDLE, valid_flit_o=0, data_o=0, busy_o=0, rr pointer=0, holdoff counters=0, remaining count=0. Reset mid-packet abandons the packet; no TAIL is emitted.
- Eligibility: VC v eligible iff on_off_i[v] & is_empty_i[v] & holdoff[v]==0.
- pkt_ready_o = (state==IDLE) & (any VC eligible); combinational.
- VC pick: first eligible VC at or after rr pointer, wrapping modulo VC_NUM. On acceptance, rr pointer <= picked+1 (wraps).
- FSM:
  - IDLE: on accept at edge E0, latch dest, head_pl, VC and len (len 0 treated as 1). Go to HEAD.
  - HEAD: at an edge with on_off_i[vc]==1, register the flit.
    - If len==1: send HEADTAIL, go to IDLE.
    - Otherwise: send HEAD, set remaining=len-1, go to BT.
    - If on_off_i[vc]==0: valid_flit_o=0 and stay in HEAD.
  - BT: pl_ready_o = on_off_i[vc] (combinational, 0 in other states). When pl_valid_i & pl_ready_o, register the flit and decrement remaining.
    - Label is TAIL when remaining==1, then go to IDLE.
    - Otherwise label is BODY, stay in BT.
- Latency: earliest HEAD is visible on data_o in the cycle after edge E1 (one edge after acceptance).
- Throughput: one flit per cycle when unstalled. Next packet can be accepted in the same cycle the TAIL is registered, because state is IDLE after that edge.
- Output registers:
  - valid_flit_o is 1 only in the cycle after a flit-producing edge, and is cleared otherwise.
  - data_o holds its last value when valid_flit_o=0.
  - vc_id is the latched VC for every flit of the packet.
  - HEAD and HEADTAIL flits carry head_data.{x_dest,y_dest,head_pl}; BODY and TAIL carry bt_pl = pl_data_i.
- on_off_i is sampled at the same edge as the send decision. A drop mid-packet stalls without loss or duplication; resume restarts from the stalled flit.
- Holdoff: at the edge sending TAIL/HEADTAIL on v, holdoff[v] <= HOLDOFF. Nonzero counters decrement by 1 each cycle and saturate at 0.
- Never interleaves packets; only one VC is active at a time.

Test Plan:
- Basic packet: on_off_i=all 1, is_empty_i=all 1, pkt_len=4, pl_valid held 1 → HEAD, BODY, BODY, TAIL on 4 consecutive cycles starting 2 edges after accept, all with vc_id=0. Payload matches pl_data_i order.
- Single flit: pkt_len=1 → exactly one HEADTAIL with dest/head_pl fields. pl_ready_o stays 0 throughout. State returns to IDLE.
- Flow-control stall: pkt_len=6, drop on_off_i[vc] for 3 cycles after the 2nd BODY → valid_flit_o=0 and pl_ready_o=0 for 3 cycles. Resume sends remaining BODY, BODY, TAIL with no gap, loss or duplicate.
- VC rotation and holdoff: 3 back-to-back 2-flit packets with VC_NUM≥3, all eligible → vc_id 0, then 1, then 2. Next packet with only VC0 empty is blocked (pkt_ready_o=0) until HOLDOFF cycles after VC0's TAIL.
- Payload starvation: pl_valid_i=0 for 2 cycles mid-packet → output bubbles only; flit count and labels unchanged.
- Reset mid-packet: rst=0 during BT of a 16-flit packet → next cycle valid_flit_o=0, busy_o=0, pkt_ready_o follows eligibility. A new packet starts with HEAD on vc_id 0.
